// File: rtl/cluster_event_dc_sink_pkg.sv
// Shared event-bus definitions for the SoC-to-cluster token-ring crossing.
package cluster_event_dc_sink_pkg;

  localparam int unsigned EVT_BUFFER_WIDTH = 8;
  localparam int unsigned EVT_EVNT_WIDTH   = 8;

  // Widest ring the helper below supports; callers truncate to their own width.
  localparam int unsigned RING_MAX = 32;

  localparam logic [RING_MAX-1:0] RP_RESET = 32'h0000_0001;

  // Rotate a one-hot ring of 'width' bits left by one; bit width-1 wraps to bit 0.
  function automatic logic [RING_MAX-1:0] ring_rotl(input logic [RING_MAX-1:0] ring,
                                                     input int unsigned       width);
    logic [RING_MAX-1:0] mask;
    mask = {RING_MAX{1'b1}} >> (RING_MAX - width);
    return ((ring << 1) | (ring >> (width - 1))) & mask;
  endfunction

endpackage

// File: rtl/cluster_event_dc_sink_sync.sv
// Per-bit two-flop synchronizer with asynchronous active-low reset to zero.
module cdc_sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/cluster_event_dc_sink.sv
// Cluster-side sink of the SoC-to-cluster event crossing: token compare,
// one-hot read pointer and a single valid/ready output register.
module cluster_event_dc_sink
  import cluster_event_dc_sink_pkg::*;
#(
  parameter int unsigned BUFFER_WIDTH = EVT_BUFFER_WIDTH,
  parameter int unsigned EVNT_WIDTH   = EVT_EVNT_WIDTH
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic [BUFFER_WIDTH-1:0] evt_wt_i,
  input  logic [EVNT_WIDTH-1:0]   evt_da_i,
  output logic [BUFFER_WIDTH-1:0] evt_rp_o,
  output logic                    evt_valid_o,
  input  logic                    evt_ready_i,
  output logic [EVNT_WIDTH-1:0]   evt_data_o
);

  logic [BUFFER_WIDTH-1:0] wt_sync;
  logic [BUFFER_WIDTH-1:0] rd_tog_q, rd_tog_d;
  logic [BUFFER_WIDTH-1:0] rp_q, rp_d;
  logic                    settle_q, settle_d;
  logic                    valid_q, valid_d;
  logic [EVNT_WIDTH-1:0]   data_q, data_d;
  logic                    occupied;
  logic                    load;

  cdc_sync_2ff #(
    .WIDTH (BUFFER_WIDTH)
  ) u_wt_sync (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .d_i    (evt_wt_i),
    .q_o    (wt_sync)
  );

  // Slot under the pointer holds data when its write and read toggles differ.
  assign occupied = |(rp_q & (wt_sync ^ rd_tog_q));
  assign load     = occupied && !settle_q && (!valid_q || evt_ready_i);

  always_comb begin
    rd_tog_d = rd_tog_q;
    rp_d     = rp_q;
    settle_d = 1'b0;
    valid_d  = valid_q;
    data_d   = data_q;
    if (load) begin
      data_d   = evt_da_i;
      valid_d  = 1'b1;
      rd_tog_d = rd_tog_q ^ rp_q;
      rp_d     = BUFFER_WIDTH'(ring_rotl(RING_MAX'(rp_q), BUFFER_WIDTH));
      // Source data mux follows the new pointer; skip one cycle before sampling.
      settle_d = 1'b1;
    end else if (valid_q && evt_ready_i) begin
      valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rd_tog_q <= '0;
      rp_q     <= BUFFER_WIDTH'(RP_RESET);
      settle_q <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= '0;
    end else begin
      rd_tog_q <= rd_tog_d;
      rp_q     <= rp_d;
      settle_q <= settle_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
    end
  end

  assign evt_rp_o    = rp_q;
  assign evt_valid_o = valid_q;
  assign evt_data_o  = data_q;

endmodule
